// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates interior-pixel codes, then streams bins out over valid/ready.
// Optional 59-bin uniform-pattern mapping enabled by defining LBP_UNIFORM_EN.
module lbp_hist #(
  parameter int unsigned COUNT_W = 14,
  parameter int unsigned IMG_W   = 128,
  parameter int unsigned IMG_H   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lbp_valid,
  input  logic [13:0]        lbp_addr,
  input  logic [7:0]         lbp_data,
  input  logic               finish,
  output logic               hist_valid,
  input  logic               hist_ready,
  output logic [7:0]         hist_bin,
  output logic [COUNT_W-1:0] hist_count,
  output logic [COUNT_W-1:0] pix_total,
  output logic               hist_done
);

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned BIN_W  = 8;
  localparam int unsigned COL_W  = $clog2(IMG_W);
`ifdef LBP_UNIFORM_EN
  localparam int unsigned NBINS  = 59;
`else
  localparam int unsigned NBINS  = 256;
`endif
  localparam int unsigned IDX_W  = $clog2(NBINS);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ACCUM, DUMP, DONE} state_t;

`ifdef LBP_UNIFORM_EN
  // Constant table: uniform codes ranked in ascending order, everything else to bin 58.
  function automatic logic [256*6-1:0] build_umap();
    logic [256*6-1:0] m;
    logic [7:0]       c;
    int               rank;
    m    = '0;
    rank = 0;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      if ($countones(c ^ {c[0], c[7:1]}) <= 2) begin
        m[i*6 +: 6] = 6'(rank);
        rank++;
      end else begin
        m[i*6 +: 6] = 6'd58;
      end
    end
    return m;
  endfunction

  localparam logic [256*6-1:0] UMAP = build_umap();
`endif

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] bin_q [NBINS];
  logic [COUNT_W-1:0] bin_d [NBINS];
  logic [COUNT_W-1:0] pix_total_q, pix_total_d;
  logic [COUNT_W-1:0] hist_count_q, hist_count_d;
  logic [BIN_W-1:0]   hist_bin_q, hist_bin_d;
  logic               hist_valid_q, hist_valid_d;
  logic               hist_done_q, hist_done_d;

  logic [IDX_W-1:0]   bin_idx_c;
  logic [IDX_W-1:0]   nxt_idx_c;
  logic [COL_W-1:0]   col_c;
  logic [ADDR_W-1:0]  row_c;
  logic               accept_c;

  // Border filter and code-to-bin mapping.
  always_comb begin
    col_c    = lbp_addr[COL_W-1:0];
    row_c    = lbp_addr >> COL_W;
    accept_c = lbp_valid
               && (col_c != '0) && (col_c != COL_W'(IMG_W - 1))
               && (row_c != '0) && (row_c <= ADDR_W'(IMG_H - 2));
`ifdef LBP_UNIFORM_EN
    bin_idx_c = IDX_W'(UMAP[32'(lbp_data)*6 +: 6]);
`else
    bin_idx_c = IDX_W'(lbp_data);
`endif
    nxt_idx_c = IDX_W'(hist_bin_q + BIN_W'(1));
  end

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    pix_total_d  = pix_total_q;
    hist_valid_d = hist_valid_q;
    hist_bin_d   = hist_bin_q;
    hist_count_d = hist_count_q;
    hist_done_d  = hist_done_q;
    case (state_q)
      ACCUM: begin
        if (accept_c) begin
          if (bin_q[bin_idx_c] != CNT_MAX) begin
            bin_d[bin_idx_c] = bin_q[bin_idx_c] + COUNT_W'(1);
          end
          if (pix_total_q != CNT_MAX) begin
            pix_total_d = pix_total_q + COUNT_W'(1);
          end
        end
        if (finish) begin
          state_d = DUMP;
        end
      end
      DUMP: begin
        // First DUMP cycle only primes bin 0, letting the last increment settle.
        if (!hist_valid_q) begin
          hist_valid_d = 1'b1;
          hist_bin_d   = '0;
          hist_count_d = bin_q[0];
        end else if (hist_ready) begin
          if (hist_bin_q == BIN_W'(NBINS - 1)) begin
            state_d      = DONE;
            hist_valid_d = 1'b0;
            hist_done_d  = 1'b1;
          end else begin
            hist_bin_d   = hist_bin_q + BIN_W'(1);
            hist_count_d = bin_q[nxt_idx_c];
          end
        end
      end
      DONE: begin
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      bin_q        <= '{default: '0};
      pix_total_q  <= '0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= '0;
      hist_count_q <= '0;
      hist_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      pix_total_q  <= pix_total_d;
      hist_valid_q <= hist_valid_d;
      hist_bin_q   <= hist_bin_d;
      hist_count_q <= hist_count_d;
      hist_done_q  <= hist_done_d;
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_count = hist_count_q;
  assign pix_total  = pix_total_q;
  assign hist_done  = hist_done_q;

endmodule
